// File: rtl/flag_status_unit.sv
// flag_status_unit: architectural NZCV status register with an exception
// shadow copy, a saturating update counter, and EX->ID forwarding or
// stall generation for the ID-stage condition checker.
// Flag vectors are ordered {Z,C,N,V}.
module flag_status_unit #(
   parameter int BYPASS  = 1,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               flush,
   input  logic               ex_valid,
   input  logic               ex_s,
   input  logic               ex_logical,
   input  logic [3:0]         alu_flags,
   input  logic               shifter_carry,
   input  logic               msr_we,
   input  logic [3:0]         msr_data,
   input  logic               save,
   input  logic               restore,
   input  logic               id_valid,
   input  logic [3:0]         id_cond,
   output logic [3:0]         sr,
   output logic [3:0]         sr_id,
   output logic               flag_hazard,
   output logic [3:0]         shadow,
   output logic [COUNT_W-1:0] upd_count
);

   localparam logic [3:0] COND_AL = 4'b1110;

   logic       ex_live;
   logic       alu_upd;
   logic       msr_upd;
   logic       pend;
   logic       sr_write;
   logic       hazard_raw;
   logic [3:0] alu_next;
   logic [3:0] pend_val;

   assign ex_live  = ex_valid & ~flush;
   assign alu_upd  = ex_live & ex_s & ~msr_we;
   assign msr_upd  = ex_live & msr_we;
   assign pend     = ~freeze & (msr_upd | alu_upd);
   assign sr_write = ~freeze & (restore | msr_upd | alu_upd);

   // ALU-sourced next flags: logical ops take C from the shifter and keep V
   always_comb begin
      alu_next = alu_flags;
      if (ex_logical) begin
         alu_next = {alu_flags[3], shifter_carry, alu_flags[1], sr[0]};
      end
   end

   // Value the pending EX write will commit; msr wins over the ALU
   always_comb begin
      pend_val = alu_next;
      if (msr_upd) begin
         pend_val = msr_data;
      end
   end

   // Raw stall condition; AL never depends on flags. Not gated by freeze.
   assign hazard_raw = id_valid & (id_cond != COND_AL) & (msr_upd | alu_upd);

   // ID-stage view of the flags: forward the in-flight write or stall
   always_comb begin
      if (BYPASS != 0) begin
         sr_id       = pend ? pend_val : sr;
         flag_hazard = 1'b0;
      end else begin
         sr_id       = sr;
         flag_hazard = hazard_raw;
      end
   end

   // Status, shadow and counter state; shadow always captures pre-edge sr,
   // so save+restore together swaps the two registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         shadow    <= '0;
         upd_count <= '0;
      end else if (!freeze) begin
         if (restore) begin
            sr <= shadow;
         end else if (msr_upd) begin
            sr <= msr_data;
         end else if (alu_upd) begin
            sr <= alu_next;
         end
         if (save) begin
            shadow <= sr;
         end
         if (sr_write && (upd_count != '1)) begin
            upd_count <= upd_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_flag_status_unit.sv
// Directed testbench for flag_status_unit. Three instances share inputs:
// default (bypass, 16-bit count), no-bypass, and a 2-bit counter.
module tb_flag_status_unit;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, ex_valid, ex_s, ex_logical;
   logic [3:0]  alu_flags;
   logic        shifter_carry, msr_we;
   logic [3:0]  msr_data;
   logic        save, restore, id_valid;
   logic [3:0]  id_cond;

   logic [3:0]  sr0, srid0, sh0;
   logic        hz0;
   logic [15:0] cnt0;
   logic [3:0]  sr1, srid1, sh1;
   logic        hz1;
   logic [15:0] cnt1;
   logic [3:0]  sr2, srid2, sh2;
   logic        hz2;
   logic [1:0]  cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   flag_status_unit #(.BYPASS(1), .COUNT_W(16)) u_byp (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .ex_valid(ex_valid),
      .ex_s(ex_s), .ex_logical(ex_logical), .alu_flags(alu_flags),
      .shifter_carry(shifter_carry), .msr_we(msr_we), .msr_data(msr_data),
      .save(save), .restore(restore), .id_valid(id_valid), .id_cond(id_cond),
      .sr(sr0), .sr_id(srid0), .flag_hazard(hz0), .shadow(sh0), .upd_count(cnt0));

   flag_status_unit #(.BYPASS(0), .COUNT_W(16)) u_nobyp (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .ex_valid(ex_valid),
      .ex_s(ex_s), .ex_logical(ex_logical), .alu_flags(alu_flags),
      .shifter_carry(shifter_carry), .msr_we(msr_we), .msr_data(msr_data),
      .save(save), .restore(restore), .id_valid(id_valid), .id_cond(id_cond),
      .sr(sr1), .sr_id(srid1), .flag_hazard(hz1), .shadow(sh1), .upd_count(cnt1));

   flag_status_unit #(.BYPASS(1), .COUNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .ex_valid(ex_valid),
      .ex_s(ex_s), .ex_logical(ex_logical), .alu_flags(alu_flags),
      .shifter_carry(shifter_carry), .msr_we(msr_we), .msr_data(msr_data),
      .save(save), .restore(restore), .id_valid(id_valid), .id_cond(id_cond),
      .sr(sr2), .sr_id(srid2), .flag_hazard(hz2), .shadow(sh2), .upd_count(cnt2));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge so registered outputs are settled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      freeze = 0; flush = 0; ex_valid = 0; ex_s = 0; ex_logical = 0;
      alu_flags = 4'b0000; shifter_carry = 0; msr_we = 0; msr_data = 4'b0000;
      save = 0; restore = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1; id_valid = 0; id_cond = 4'b1110;
      tick(); tick();
      rst = 0;
      #1;
      chk("reset_sr",     16'(sr0),  16'h0);
      chk("reset_shadow", 16'(sh0),  16'h0);
      chk("reset_count",  16'(cnt0), 16'h0);
      chk("reset_sr_id",  16'(srid0), 16'h0);
      chk("reset_hazard", 16'(hz1),  16'h0);

      // Arithmetic update; check same-cycle forward and stall paths
      ex_valid = 1; ex_s = 1; ex_logical = 0; alu_flags = 4'b1010;
      id_valid = 1; id_cond = 4'b0000;
      #1;
      chk("bypass_sr_id",   16'(srid0), 16'hA);
      chk("nobyp_sr_id",    16'(srid1), 16'h0);
      chk("nobyp_hazard_eq",16'(hz1),   16'h1);
      chk("byp_hazard",     16'(hz0),   16'h0);
      id_cond = 4'b1110;
      #1;
      chk("nobyp_hazard_al",16'(hz1),   16'h0);
      tick();
      chk("arith_sr",    16'(sr0),  16'hA);
      chk("arith_count", 16'(cnt0), 16'h1);
      chk("sat_count1",  16'(cnt2), 16'h1);

      // MSR write sets up sr=0001
      ex_s = 0; msr_we = 1; msr_data = 4'b0001;
      tick();
      chk("msr_sr", 16'(sr0), 16'h1);

      // Logical op: Z,N from ALU, C from shifter, V kept from sr
      msr_we = 0; ex_s = 1; ex_logical = 1; alu_flags = 4'b0110; shifter_carry = 1;
      tick();
      chk("logical_sr",    16'(sr0),  16'h7);
      chk("logical_count", 16'(cnt0), 16'h3);
      chk("sat_count3",    16'(cnt2), 16'h3);

      // MSR beats ALU in the same cycle
      ex_logical = 0; shifter_carry = 0; alu_flags = 4'b0011;
      msr_we = 1; msr_data = 4'b1100;
      #1;
      chk("prio_sr_id", 16'(srid0), 16'hC);
      tick();
      chk("prio_sr",    16'(sr0),  16'hC);
      chk("prio_count", 16'(cnt0), 16'h4);

      // Flush squashes both write sources and the hazard
      flush = 1; msr_data = 4'b0101; id_cond = 4'b0000;
      #1;
      chk("flush_hazard", 16'(hz1),   16'h0);
      chk("flush_sr_id",  16'(srid0), 16'hC);
      tick();
      chk("flush_sr",    16'(sr0),  16'hC);
      chk("flush_count", 16'(cnt0), 16'h4);

      // sr=0101, then write 1000 while saving: shadow gets pre-edge 0101
      flush = 0; ex_s = 0; msr_data = 4'b0101;
      tick();
      msr_data = 4'b1000; save = 1;
      tick();
      chk("savewr_sr",     16'(sr0), 16'h8);
      chk("savewr_shadow", 16'(sh0), 16'h5);

      // Save + restore together swap
      msr_we = 0; ex_valid = 0; save = 1; restore = 1;
      tick();
      chk("swap_sr",     16'(sr0),  16'h5);
      chk("swap_shadow", 16'(sh0),  16'h8);
      chk("swap_count",  16'(cnt0), 16'h7);

      // Freeze holds everything; hazard still raised
      freeze = 1; ex_valid = 1; ex_s = 1; alu_flags = 4'b1111;
      #1;
      chk("freeze_sr_id",  16'(srid0), 16'h5);
      chk("freeze_hazard", 16'(hz1),   16'h1);
      tick();
      chk("freeze_sr",     16'(sr0),  16'h5);
      chk("freeze_shadow", 16'(sh0),  16'h8);
      chk("freeze_count",  16'(cnt0), 16'h7);

      // Restore beats MSR
      freeze = 0; save = 0; restore = 1; ex_s = 0; msr_we = 1; msr_data = 4'b0011;
      tick();
      chk("restore_sr",    16'(sr0),  16'h8);
      chk("restore_count", 16'(cnt0), 16'h8);
      chk("nobyp_sr",      16'(sr1),  16'h8);
      chk("sat_count_end", 16'(cnt2), 16'h3);

      // Reset overrides simultaneous update/save
      restore = 0; save = 1; rst = 1;
      tick();
      rst = 0; idle_inputs();
      #1;
      chk("midrst_sr",     16'(sr0),  16'h0);
      chk("midrst_shadow", 16'(sh0),  16'h0);
      chk("midrst_count",  16'(cnt0), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_status_unit.md
Name: flag_status_unit

Overview:
- Holds the architectural NZCV status register for the ARM pipeline.
- Sources flag updates from the EX stage: ALU results with the S bit set, and direct MSR-style writes.
- Presents the status value to the ID-stage condition checker, with optional EX->ID bypass or a stall request when bypass is disabled.
- Keeps a shadow copy for exception save/restore and a saturating count of flag updates.

Parameters:
BYPASS, 1, 1 = forward the in-flight EX flag write to sr_id; 0 = raise flag_hazard instead.
COUNT_W, 16, width of the saturating flag-update counter.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  pipeline stall; all state holds
flush  in  1  squash the current EX instruction
ex_valid  in  1  EX stage holds a valid instruction
ex_s  in  1  S bit of the EX instruction
ex_logical  in  1  1 = logical/move op, 0 = arithmetic/compare
alu_flags  in  4  ALU flags, ordered {Z,C,N,V}
shifter_carry  in  1  barrel-shifter carry-out
msr_we  in  1  direct status write from EX
msr_data  in  4  direct write value {Z,C,N,V}
save  in  1  copy sr into shadow (exception entry)
restore  in  1  copy shadow into sr (exception return)
id_valid  in  1  ID stage holds a valid instruction
id_cond  in  4  condition field of the ID instruction
sr  out  4  registered status {Z,C,N,V}
sr_id  out  4  status value delivered to the condition checker
flag_hazard  out  1  stall request to the hazard unit
shadow  out  4  saved status
upd_count  out  COUNT_W  number of committed sr writes, saturating

Behaviour:
- Reset: when rst=1 at a clock edge, sr=0, shadow=0, upd_count=0. flag_hazard and sr_id follow from the reset state (sr_id=0).
- ex_live = ex_valid & ~flush.
- alu_upd = ex_live & ex_s & ~msr_we.
- msr_upd = ex_live & msr_we.
- Arithmetic update (ex_logical=0):
  - next = alu_flags.
- Logical update (ex_logical=1):
  - Z = alu_flags[3], C = shifter_carry, N = alu_flags[1].
  - V holds at sr[0].
- Write priority for sr at the clock edge:
  1. rst
  2. freeze (hold everything)
  3. restore (sr <= shadow)
  4. msr_upd (sr <= msr_data)
  5. alu_upd
  6. hold
- Any lower-priority source is dropped for that cycle, not deferred.
- save: shadow <= the pre-edge sr value, even if sr is written in the same cycle.
  - save and restore together: swap (sr <= old shadow, shadow <= old sr).
  - Both are ignored under freeze.
- flush suppresses msr_upd and alu_upd only; save and restore are unaffected.
- upd_count increments by 1 on every edge where sr is written (restore, msr or alu) and freeze=0. It saturates at all-ones and does not wrap.
- pend = ~freeze & (msr_upd | alu_upd). pend_val is the value that write will commit.
- BYPASS=1:
  - sr_id = pend ? pend_val : sr, combinational, zero-cycle forward.
  - flag_hazard = 0.
- BYPASS=0:
  - sr_id = sr.
  - flag_hazard = id_valid & (id_cond != 4'b1110) & (msr_upd | alu_upd), combinational.
  - AL (4'b1110) never stalls.
  - The hazard is evaluated regardless of freeze.
- restore is not bypassed. The exception controller flushes ID on restore.
- Latency: a write is visible on sr one cycle after the qualifying edge. With BYPASS=1 it is visible on sr_id in the same cycle.
- Reset mid-operation overrides every pending save, restore or update in that cycle.

Test Plan:
- Reset, then arithmetic update: rst for 2 cycles, then ex_valid=1, ex_s=1, ex_logical=0, alu_flags=4'b1010 -> sr=4'b1010 next cycle, upd_count=1.
- Logical update preserves V: sr=4'b0001, then logical op with alu_flags=4'b0110, shifter_carry=1 -> sr=4'b0111.
- Priority and flush:
  - msr_we=1 (msr_data=4'b1100) with ex_s=1 (alu_flags=4'b0011) -> sr=4'b1100.
  - Same stimulus with flush=1 -> sr unchanged, upd_count unchanged.
- Freeze holds everything: freeze=1 with ALU update, save and restore asserted -> sr, shadow and upd_count unchanged.
- Save/restore swap: sr=4'b1000, shadow=4'b0101, save=restore=1 -> sr=4'b0101, shadow=4'b1000.
- Bypass and hazard:
  - BYPASS=1, pending alu_flags=4'b1000 with sr=0 -> sr_id=4'b1000 in the same cycle.
  - BYPASS=0, id_cond=EQ, id_valid=1 -> flag_hazard=1.
  - BYPASS=0, id_cond=AL -> flag_hazard=0.
  - With COUNT_W=2 after 5 updates -> upd_count=3.
